mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one synchronous SRAM port between the IF stage (instruction fetch) and the EX/MEM stage (loads/stores).
//   Issues at most one access per cycle; blocks new issue while a read is outstanding; returns read data
//   to the owner with a one-cycle valid pulse. Data side has priority; a starvation counter guarantees fetch progress.
//   Sits between pc/execute and the memory wrapper; its gnt outputs drive the pipeline stall logic.
// PARAMETERS
//   ADDR_W      32  address width
//   DATA_W      32  data width
//   RD_LAT       1  cycles from read issue (mem_en & ~|mem_wen) to valid mem_rdata; range 1..7
//   STARVE_MAX   4  consecutive data grants while inst_req pending before inst is forced one grant; >=1
// PORTS
//   clk          in   1        clock
//   rst          in   1        synchronous reset, active-high
//   flush_i      in   1        pipeline flush: drop the outstanding read's response
//   inst_req     in   1        fetch request (held with inst_addr until inst_gnt)
//   inst_addr    in   ADDR_W   fetch address
//   inst_gnt     out  1        fetch accepted this cycle
//   inst_rvalid  out  1        inst_rdata valid this cycle
//   inst_rdata   out  DATA_W   fetch data
//   data_req     in   1        load/store request (held with attrs until data_gnt)
//   data_wen     in   4        byte write enables; 0 = load
//   data_addr    in   ADDR_W   data address
//   data_wdata   in   DATA_W   store data
//   data_gnt     out  1        load/store accepted this cycle
//   data_rvalid  out  1        data_rdata valid this cycle (loads only)
//   data_rdata   out  DATA_W   load data
//   mem_en       out  1        SRAM enable
//   mem_wen      out  4        SRAM byte write enables
//   mem_addr     out  ADDR_W   SRAM address
//   mem_wdata    out  DATA_W   SRAM write data
//   mem_rdata    in   DATA_W   SRAM read data, valid RD_LAT cycles after read issue
// BEHAVIOUR
//   - States: IDLE (port free), RD_WAIT (read outstanding; owner reg = I or D; down-counter cnt).
//   - can_issue = IDLE, or RD_WAIT with cnt==1 (response cycle): back-to-back reads at 1 per RD_LAT cycles.
//   - Arbitration when can_issue: pick D if data_req && !(inst_req && starve==STARVE_MAX); else I if inst_req.
//   - Issue is combinational: chosen gnt=1, mem_en=1, mem_addr/wen/wdata = winner's inputs; loser gnt=0.
//     No issue -> mem_en=0, mem_wen=0, mem_addr/mem_wdata=0.
//   - Store (data_wen!=0): completes in issue cycle; no rvalid; state unchanged by it (stays/returns IDLE).
//   - Read issue: next state RD_WAIT, cnt<=RD_LAT, owner<=winner, drop<=0. cnt decrements each RD_WAIT cycle.
//   - Response cycle (RD_WAIT, cnt==1): owner's rvalid=1 unless drop; {inst,data}_rdata = mem_rdata
//     (combinational pass-through; value is don't-care when rvalid=0). Exit to IDLE unless a new read issues.
//   - flush_i in RD_WAIT (incl. response cycle): drop<=1 / rvalid suppressed that cycle; port still stays
//     busy until the response cycle (SRAM is not cancellable). flush_i does not block same-cycle issue.
//   - starve (0..STARVE_MAX, saturating): +1 on data grant while inst_req=1; cleared on inst grant or inst_req=0.
//   - Simultaneous store grant with read response: allowed (different cycle roles; response uses mem_rdata only).
//   - Reset: state IDLE, cnt=0, owner=I, drop=0, starve=0; all gnt/rvalid/mem_en/mem_wen = 0.
//     Reset mid-read discards the response: no rvalid after rst deasserts for the pending read.
//   - Requesters must hold req and attributes stable until gnt; arbiter does not latch unaccepted requests.
// TESTING
//   1 RD_LAT=1, inst_req @0x1fc00000 alone -> cyc0 inst_gnt=1,mem_en=1,mem_wen=0; cyc1 inst_rvalid=1, rdata=mem_rdata.
//   2 inst_req & data_req(load @0x80) same cycle -> data_gnt=1,inst_gnt=0; inst granted in data's response cycle.
//   3 STARVE_MAX=4, data_req+inst_req held 10 cycles, all stores -> grants D,D,D,D,I,D,D,D,D,I.
//   4 RD_LAT=3 load issued, flush_i at cycle+1 -> data_rvalid stays 0; no mem_en until cycle+3; cycle+3 issue ok.
//   5 Store wen=4'b0011 addr 0x100 wdata 0xdeadbeef -> mem_wen=0011,mem_wdata=0xdeadbeef same cycle, no rvalid.
//   6 Load issued, rst=1 next cycle for 1 cycle -> all outputs 0; no data_rvalid afterwards; new req granted at once.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous SRAM port between instruction fetch and load/store.
// Data side wins arbitration unless fetch has been starved STARVE_MAX grants in a row.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_gnt,
  output logic              inst_rvalid,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W    = 3;
  localparam int STARVE_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]    CNT_INIT   = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);
  localparam logic [STARVE_W-1:0] STARVE_ONE = STARVE_W'(1);

  typedef enum logic {IDLE, RD_WAIT} state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                drop_q, drop_d;
  logic [STARVE_W-1:0] starve_q, starve_d;

  logic resp;
  logic can_issue;
  logic pick_d;
  logic pick_i;
  logic deliver;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_I;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      starve_q <= starve_d;
    end
  end

  // The response cycle doubles as an issue slot so reads can stream every RD_LAT cycles.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    drop_d      = drop_q;
    starve_d    = starve_q;
    inst_gnt    = 1'b0;
    data_gnt    = 1'b0;
    inst_rvalid = 1'b0;
    data_rvalid = 1'b0;
    mem_en      = 1'b0;
    mem_wen     = 4'b0000;
    mem_addr    = '0;
    mem_wdata   = '0;
    inst_rdata  = mem_rdata;
    data_rdata  = mem_rdata;

    resp      = (state_q == RD_WAIT) && (cnt_q == CNT_ONE);
    can_issue = !rst && ((state_q == IDLE) || resp);
    pick_d    = can_issue && data_req && !(inst_req && (starve_q == STARVE_TOP));
    pick_i    = can_issue && !pick_d && inst_req;
    deliver   = !rst && resp && !drop_q && !flush_i;

    if (deliver) begin
      inst_rvalid = (owner_q == OWN_I);
      data_rvalid = (owner_q == OWN_D);
    end

    if (state_q == RD_WAIT) begin
      if (resp) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
      drop_d = drop_q | flush_i;
    end

    if (pick_d) begin
      data_gnt  = 1'b1;
      mem_en    = 1'b1;
      mem_wen   = data_wen;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
      if (data_wen == 4'b0000) begin
        state_d = RD_WAIT;
        cnt_d   = CNT_INIT;
        owner_d = OWN_D;
        drop_d  = 1'b0;
      end
    end else if (pick_i) begin
      inst_gnt = 1'b1;
      mem_en   = 1'b1;
      mem_addr = inst_addr;
      state_d  = RD_WAIT;
      cnt_d    = CNT_INIT;
      owner_d  = OWN_I;
      drop_d   = 1'b0;
    end

    if (pick_d && inst_req) begin
      starve_d = (starve_q == STARVE_TOP) ? STARVE_TOP : starve_q + STARVE_ONE;
    end else if (pick_i || !inst_req) begin
      starve_d = '0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with RD_LAT=1, one with RD_LAT=3,
// sharing stimulus; each step checks only the instance it targets.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        data_req = 1'b0;
  logic [3:0]  data_wen = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] mem_rdata = '0;

  logic        a_inst_gnt, a_inst_rvalid, a_data_gnt, a_data_rvalid, a_mem_en;
  logic [31:0] a_inst_rdata, a_data_rdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_wen;
  logic        b_inst_gnt, b_inst_rvalid, b_data_gnt, b_data_rvalid, b_mem_en;
  logic [31:0] b_inst_rdata, b_data_rdata, b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_wen;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .STARVE_MAX(4)) u_lat1 (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(a_inst_gnt),
    .inst_rvalid(a_inst_rvalid), .inst_rdata(a_inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(a_data_gnt), .data_rvalid(a_data_rvalid), .data_rdata(a_data_rdata),
    .mem_en(a_mem_en), .mem_wen(a_mem_wen), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3), .STARVE_MAX(4)) u_lat3 (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(b_inst_gnt),
    .inst_rvalid(b_inst_rvalid), .inst_rdata(b_inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(b_data_gnt), .data_rvalid(b_data_rvalid), .data_rdata(b_data_rdata),
    .mem_en(b_mem_en), .mem_wen(b_mem_wen), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkFlag(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the clock edge; outputs are sampled 1 unit later.
  task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                               input logic dreq, input logic [3:0] dwen,
                               input logic [31:0] daddr, input logic [31:0] dwdata,
                               input logic flush, input logic [31:0] rdata);
    inst_req   = ireq;
    inst_addr  = iaddr;
    data_req   = dreq;
    data_wen   = dwen;
    data_addr  = daddr;
    data_wdata = dwdata;
    flush_i    = flush;
    mem_rdata  = rdata;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    $display("[TB] start");
    // Reset state
    applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick;
    tick;
    checkFlag("rst_a_mem_en", a_mem_en, 1'b0);
    checkFlag("rst_b_mem_en", b_mem_en, 1'b0);
    checkFlag("rst_a_inst_rvalid", a_inst_rvalid, 1'b0);
    checkFlag("rst_a_data_rvalid", a_data_rvalid, 1'b0);
    rst = 1'b0;

    // Test 1: lone fetch, RD_LAT=1
    applyStimulus(1'b1, 32'h1fc00000, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkFlag("t1_inst_gnt", a_inst_gnt, 1'b1);
    checkFlag("t1_mem_en", a_mem_en, 1'b1);
    checkOutput("t1_mem_wen", 32'(a_mem_wen), 32'h0);
    checkOutput("t1_mem_addr", a_mem_addr, 32'h1fc00000);
    tick;
    applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h11223344);
    checkFlag("t1_inst_rvalid", a_inst_rvalid, 1'b1);
    checkOutput("t1_inst_rdata", a_inst_rdata, 32'h11223344);
    checkFlag("t1_data_rvalid", a_data_rvalid, 1'b0);
    checkFlag("t1_mem_en_idle", a_mem_en, 1'b0);
    tick;

    // Test 2: simultaneous fetch and load, data wins
    doReset;
    applyStimulus(1'b1, 32'h1fc00004, 1'b1, 4'h0, 32'h80, 32'h0, 1'b0, 32'h0);
    checkFlag("t2_data_gnt", a_data_gnt, 1'b1);
    checkFlag("t2_inst_gnt", a_inst_gnt, 1'b0);
    checkOutput("t2_mem_addr", a_mem_addr, 32'h80);
    tick;
    applyStimulus(1'b1, 32'h1fc00004, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'hcafef00d);
    checkFlag("t2_data_rvalid", a_data_rvalid, 1'b1);
    checkOutput("t2_data_rdata", a_data_rdata, 32'hcafef00d);
    checkFlag("t2_inst_gnt_resp", a_inst_gnt, 1'b1);
    checkOutput("t2_mem_addr_inst", a_mem_addr, 32'h1fc00004);
    tick;
    applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0badf00d);
    checkFlag("t2_inst_rvalid", a_inst_rvalid, 1'b1);
    checkOutput("t2_inst_rdata", a_inst_rdata, 32'h0badf00d);
    checkFlag("t2_data_rvalid_off", a_data_rvalid, 1'b0);
    tick;

    // Test 3: starvation guard with back-to-back stores
    doReset;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 32'h1fc00008, 1'b1, 4'hf, 32'h200, 32'h12345678, 1'b0, 32'h0);
      checkFlag($sformatf("t3_inst_gnt_%0d", i), a_inst_gnt, (i == 4) || (i == 9));
      checkFlag($sformatf("t3_data_gnt_%0d", i), a_data_gnt, !((i == 4) || (i == 9)));
      tick;
    end

    // Test 4: flushed load with RD_LAT=3, port stays busy until response cycle
    doReset;
    applyStimulus(1'b0, 32'h0, 1'b1, 4'h0, 32'h84, 32'h0, 1'b0, 32'h0);
    checkFlag("t4_data_gnt", b_data_gnt, 1'b1);
    checkFlag("t4_mem_en_c0", b_mem_en, 1'b1);
    tick;
    applyStimulus(1'b1, 32'h1fc00010, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0);
    checkFlag("t4_mem_en_c1", b_mem_en, 1'b0);
    checkFlag("t4_inst_gnt_c1", b_inst_gnt, 1'b0);
    checkFlag("t4_data_rvalid_c1", b_data_rvalid, 1'b0);
    tick;
    applyStimulus(1'b1, 32'h1fc00010, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkFlag("t4_mem_en_c2", b_mem_en, 1'b0);
    tick;
    applyStimulus(1'b1, 32'h1fc00010, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h55aa55aa);
    checkFlag("t4_data_rvalid_c3", b_data_rvalid, 1'b0);
    checkFlag("t4_inst_gnt_c3", b_inst_gnt, 1'b1);
    checkFlag("t4_mem_en_c3", b_mem_en, 1'b1);
    checkOutput("t4_mem_addr_c3", b_mem_addr, 32'h1fc00010);
    tick;
    applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkFlag("t4_mem_en_c4", b_mem_en, 1'b0);
    checkFlag("t4_inst_rvalid_c4", b_inst_rvalid, 1'b0);
    tick;
    checkFlag("t4_inst_rvalid_c5", b_inst_rvalid, 1'b0);
    tick;
    applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h600dc0de);
    checkFlag("t4_inst_rvalid_c6", b_inst_rvalid, 1'b1);
    checkOutput("t4_inst_rdata_c6", b_inst_rdata, 32'h600dc0de);
    checkFlag("t4_data_rvalid_c6", b_data_rvalid, 1'b0);
    tick;

    // Test 5: partial store
    doReset;
    applyStimulus(1'b0, 32'h0, 1'b1, 4'b0011, 32'h100, 32'hdeadbeef, 1'b0, 32'h0);
    checkFlag("t5_data_gnt", a_data_gnt, 1'b1);
    checkOutput("t5_mem_wen", 32'(a_mem_wen), 32'h3);
    checkOutput("t5_mem_addr", a_mem_addr, 32'h100);
    checkOutput("t5_mem_wdata", a_mem_wdata, 32'hdeadbeef);
    tick;
    applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkFlag("t5_data_rvalid", a_data_rvalid, 1'b0);
    checkFlag("t5_mem_en_after", a_mem_en, 1'b0);
    tick;

    // Test 6: reset during an outstanding load (RD_LAT=3)
    doReset;
    applyStimulus(1'b0, 32'h0, 1'b1, 4'h0, 32'h88, 32'h0, 1'b0, 32'h0);
    checkFlag("t6_data_gnt", b_data_gnt, 1'b1);
    tick;
    rst = 1'b1;
    applyStimulus(1'b1, 32'h1fc00020, 1'b1, 4'h0, 32'h8c, 32'h0, 1'b0, 32'h0);
    checkFlag("t6_rst_inst_gnt", b_inst_gnt, 1'b0);
    checkFlag("t6_rst_data_gnt", b_data_gnt, 1'b0);
    checkFlag("t6_rst_mem_en", b_mem_en, 1'b0);
    checkOutput("t6_rst_mem_wen", 32'(b_mem_wen), 32'h0);
    checkFlag("t6_rst_data_rvalid", b_data_rvalid, 1'b0);
    tick;
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1, 4'h0, 32'h90, 32'h0, 1'b0, 32'h0);
    checkFlag("t6_new_data_gnt", b_data_gnt, 1'b1);
    checkFlag("t6_data_rvalid_r0", b_data_rvalid, 1'b0);
    tick;
    applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkFlag("t6_data_rvalid_r1", b_data_rvalid, 1'b0);
    tick;
    checkFlag("t6_data_rvalid_r2", b_data_rvalid, 1'b0);
    tick;
    applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h77665544);
    checkFlag("t6_data_rvalid_r3", b_data_rvalid, 1'b1);
    checkOutput("t6_data_rdata_r3", b_data_rdata, 32'h77665544);
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
